sysmem_ctrl: RTL and testbench
==============================

# sysmem_ctrl

Bus-side initiator that drives the four 8-bit single-port BRAM byte lanes of the system memory on behalf of the picorv32 native memory interface. It accepts one word transaction at a time. It decodes the address window and asserts the lane chip-enable and per-lane write enables. For reads it returns the 32-bit word with a fixed, handshaked latency. It sits between the CPU bus fabric and the byte-lane memories (lanes 0..3 = mem bits 7:0 .. 31:24).

## Interface
- BASE_ADDR, 32'h0000_0000, byte address of the memory window; must be aligned to 4·2^ADDR_W.
- ADDR_W, 10, word-address width (1024 words = 4 KiB window).
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- mem_valid  in  1  CPU request valid.
- mem_addr  in  32  CPU byte address.
- mem_wdata  in  32  CPU write data.
- mem_wstrb  in  4  byte write strobes; 4'b0000 = read.
- mem_ready  out  1  transaction complete; one-cycle pulse.
- mem_rdata  out  32  read data; valid while mem_ready=1 on a read, else 0.
- bram_addr  out  ADDR_W  word address to all four lanes.
- bram_ce  out  1  chip enable to all lanes.
- bram_we  out  4  per-lane write enable (bit n → lane n).
- bram_di  out  32  write data, lane n = bits 8n+7:8n.
- bram_do  in  32  lane read data, concatenated the same way.
- bram_rst  out  1  lane output reset; equals rst.
- err_misalign  out  1  sticky flag: an in-window request had mem_addr[1:0]≠0.

## Operation
- Window select: sel = mem_valid & (mem_addr[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]). A request with sel=0 is ignored: no BRAM activity, no mem_ready, and the FSM stays IDLE.
- FSM states: IDLE, ACC, RESP.
  - IDLE→ACC when sel=1.
  - ACC→RESP unconditionally.
  - RESP→IDLE unconditionally.
- On IDLE→ACC, register:
  - bram_addr ← mem_addr[ADDR_W+1:2]
  - bram_di ← mem_wdata
  - bram_we ← mem_wstrb
  - bram_ce ← 1
  - wr_flag ← |mem_wstrb
- In ACC, the BRAM samples the address, write data and enables on the closing edge.
- On ACC→RESP, clear bram_ce and bram_we to 0. bram_addr and bram_di hold their values.
- In RESP: mem_ready=1, and mem_rdata = wr_flag ? 32'h0 : bram_do.
- In IDLE and ACC: mem_ready=0 and mem_rdata=0.
- Partial writes touch only the strobed lanes. Unstrobed lanes keep their contents.
- Misaligned request: it is serviced at the aligned word (addr[1:0] is dropped). err_misalign is set and stays set until rst.
- mem_valid is sampled only in IDLE. Changes to mem_addr, mem_wdata or mem_wstrb during ACC or RESP have no effect.
- If mem_valid and sel are still high in the IDLE cycle after RESP, that is a new transaction.
- bram_rst = rst, combinational pass-through.

## Timing
- Reset values, applied immediately and asynchronously:
  - state=IDLE, mem_ready=0, mem_rdata=0.
  - bram_ce=0, bram_we=0, bram_addr=0, bram_di=0.
  - wr_flag=0, err_misalign=0.
- Latency: request sampled at edge E0. bram_ce is high in cycle E0–E1. mem_ready is high in cycle E1–E2, and the CPU samples it at E2.
- Back-to-back transactions: one every 3 cycles (IDLE, ACC, RESP).
- mem_ready never stays high for more than one cycle, and is never high two cycles in a row.
- rst asserted in ACC or RESP aborts the transaction: no mem_ready is issued. A write whose ACC→RESP edge has not occurred is not guaranteed to land.
- bram_we is high only in ACC. bram_we=0 whenever bram_ce=0.

## Test plan
- Reset: assert rst mid-ACC of a write. Required: all outputs 0 at once, no mem_ready, state returns to IDLE after release.
- Word write then read: write 32'hDEADBEEF to BASE+0x10 (wstrb=1111), then read it. Required: bram_addr=4 with bram_we=1111 for one cycle; read mem_rdata=32'hDEADBEEF with mem_ready exactly 2 cycles after the request edge.
- Byte strobes: preload 32'h11223344 at word 5, write 32'hAABBCCDD with wstrb=0101, then read. Required: 32'h11BB33DD.
- Out of window: mem_valid=1 at BASE+0x1000 for 10 cycles. Required: bram_ce=0 and mem_ready=0 throughout.
- Misaligned and back-to-back: read BASE+0x13 with mem_valid held high for two transactions. Required: word 4 returned twice, ready pulses 3 cycles apart, err_misalign=1 until reset.
- Power-on contents: read words 0..2. Required: mem_rdata equals the memory's power-on image; a write wstrb=0000 read never asserts bram_we.

Source files
------------

// File: rtl/sysmem_ctrl_if.sv
// CPU-side native memory bus and BRAM byte-lane bus bundles for sysmem_ctrl.
// The master modport is the initiator on each bus, and the slave modport is the responder.
interface sysmem_cpu_if;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport master (output mem_valid, mem_addr, mem_wdata, mem_wstrb,
                    input  mem_ready, mem_rdata);
    modport slave  (input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
                    output mem_ready, mem_rdata);
endinterface

interface sysmem_bram_if #(parameter int ADDR_W = 10);
    logic [ADDR_W-1:0] bram_addr;
    logic              bram_ce;
    logic [3:0]        bram_we;
    logic [31:0]       bram_di;
    logic [31:0]       bram_do;
    logic              bram_rst;

    modport master (output bram_addr, bram_ce, bram_we, bram_di, bram_rst,
                    input  bram_do);
    modport slave  (input  bram_addr, bram_ce, bram_we, bram_di, bram_rst,
                    output bram_do);
endinterface

// File: rtl/sysmem_ctrl.sv
// Drives four 8-bit BRAM byte lanes for a picorv32 native bus, one word per transaction.
// Latency: request edge E0, lane access in ACC, mem_ready pulse in the following cycle; there is no backpressure, and one transaction is issued every 3 cycles.
module sysmem_ctrl #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          ADDR_W    = 10
) (
    input  logic           clk,
    input  logic           rst,
    sysmem_cpu_if.slave    cpu,
    sysmem_bram_if.master  bram,
    output logic           err_misalign
);

    typedef enum logic [1:0] {IDLE, ACC, RESP} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       di_q, di_d;
    logic [3:0]        we_q, we_d;
    logic              ce_q, ce_d;
    logic              wr_q, wr_d;
    logic              err_q, err_d;
    logic              sel;

    assign sel = cpu.mem_valid &&
                 (cpu.mem_addr[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            di_q    <= '0;
            we_q    <= '0;
            ce_q    <= 1'b0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            di_q    <= di_d;
            we_q    <= we_d;
            ce_q    <= ce_d;
            wr_q    <= wr_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        di_d    = di_q;
        we_d    = we_q;
        ce_d    = ce_q;
        wr_d    = wr_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (sel) begin
                    state_d = ACC;
                    addr_d  = cpu.mem_addr[ADDR_W+1:2];
                    di_d    = cpu.mem_wdata;
                    we_d    = cpu.mem_wstrb;
                    ce_d    = 1'b1;
                    wr_d    = |cpu.mem_wstrb;
                    // Misaligned requests still complete, at the aligned word.
                    if (cpu.mem_addr[1:0] != 2'b00) err_d = 1'b1;
                end
            end
            ACC: begin
                state_d = RESP;
                ce_d    = 1'b0;
                we_d    = 4'b0000;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign cpu.mem_ready  = (state_q == RESP);
    assign cpu.mem_rdata  = (state_q == RESP && !wr_q) ? bram.bram_do : 32'h0;

    assign bram.bram_addr = addr_q;
    assign bram.bram_di   = di_q;
    assign bram.bram_we   = we_q;
    assign bram.bram_ce   = ce_q;
    assign bram.bram_rst  = rst;
    assign err_misalign   = err_q;

endmodule

// File: tb/tb_sysmem_ctrl.sv
// Testbench for sysmem_ctrl: a byte-lane BRAM model, directed vector table, corner sequences, and random traffic checked against a word-level reference memory.
module tb_sysmem_ctrl;

    localparam int AW = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic err_misalign;

    sysmem_cpu_if             cpu ();
    sysmem_bram_if #(.ADDR_W(AW)) bram ();

    sysmem_ctrl #(.BASE_ADDR(32'h0000_0000), .ADDR_W(AW)) dut (
        .clk          (clk),
        .rst          (rst),
        .cpu          (cpu.slave),
        .bram         (bram.master),
        .err_misalign (err_misalign)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] img(input int i);
        return 32'hA500_0000 | (i * 32'h0000_1111);
    endfunction

    // Byte-lane memories: synchronous read-first, per-lane write enable.
    logic [31:0] lane_mem [0:(1<<AW)-1];
    logic [31:0] do_q = 32'h0;
    assign bram.bram_do = do_q;

    initial begin
        for (int i = 0; i < (1<<AW); i++) lane_mem[i] <= img(i);
    end

    always @(posedge clk) begin
        if (bram.bram_ce) begin
            do_q <= lane_mem[bram.bram_addr];
            for (int n = 0; n < 4; n++)
                if (bram.bram_we[n]) lane_mem[bram.bram_addr][8*n +: 8] <= bram.bram_di[8*n +: 8];
        end
    end

    // Reference model: one word per address, plus byte-merge on writes.
    logic [31:0] ref_mem [0:(1<<AW)-1];

    int checks = 0;
    int errs   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Issue one in-window transaction from just after a rising edge; check every phase.
    task automatic txn(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] st,
                       input logic [31:0] exp, input string nm);
        logic [AW-1:0] w;
        w = a[AW+1:2];
        cpu.mem_valid = 1'b1; cpu.mem_addr = a; cpu.mem_wdata = wd; cpu.mem_wstrb = st;
        @(posedge clk); #1;
        chk({nm, " ce"},   {31'b0, bram.bram_ce}, 32'd1);
        chk({nm, " addr"}, {22'b0, bram.bram_addr}, {22'b0, w});
        chk({nm, " we"},   {28'b0, bram.bram_we}, {28'b0, st});
        if (st != 4'b0000) chk({nm, " di"}, bram.bram_di, wd);
        chk({nm, " rdy0"}, {31'b0, cpu.mem_ready}, 32'd0);
        // Bus changes during ACC/RESP must be ignored.
        cpu.mem_valid = 1'b0; cpu.mem_addr = $urandom; cpu.mem_wdata = $urandom; cpu.mem_wstrb = 4'($urandom);
        @(posedge clk); #1;
        chk({nm, " rdy1"},  {31'b0, cpu.mem_ready}, 32'd1);
        chk({nm, " rdata"}, cpu.mem_rdata, exp);
        chk({nm, " ce/we off"}, {27'b0, bram.bram_ce, bram.bram_we}, 32'd0);
        @(posedge clk); #1;
        chk({nm, " rdy2"}, {31'b0, cpu.mem_ready}, 32'd0);
        for (int n = 0; n < 4; n++)
            if (st[n]) ref_mem[w][8*n +: 8] = wd[8*n +: 8];
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t tbl [10];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] a, d, e;
        logic [3:0]  s;
        int          pulses [$];
        logic        prev_rdy;

        tbl[0] = '{32'h10, 32'hDEADBEEF, 4'b1111, 32'h0};
        tbl[1] = '{32'h10, 32'h0,        4'b0000, 32'hDEADBEEF};
        tbl[2] = '{32'h14, 32'h11223344, 4'b1111, 32'h0};
        tbl[3] = '{32'h14, 32'hAABBCCDD, 4'b0101, 32'h0};
        tbl[4] = '{32'h14, 32'h0,        4'b0000, 32'h11BB33DD};
        tbl[5] = '{32'h00, 32'h0,        4'b0000, 32'hA5000000};
        tbl[6] = '{32'h04, 32'h0,        4'b0000, 32'hA5001111};
        tbl[7] = '{32'h08, 32'h0,        4'b0000, 32'hA5002222};
        tbl[8] = '{32'h20, 32'hFFFFFFFF, 4'b0000, 32'hA5008888};
        tbl[9] = '{32'h20, 32'h0,        4'b0000, 32'hA5008888};

        for (int i = 0; i < (1<<AW); i++) ref_mem[i] = img(i);
        cpu.mem_valid = 1'b0; cpu.mem_addr = 32'h0; cpu.mem_wdata = 32'h0; cpu.mem_wstrb = 4'h0;

        // Reset state.
        #2;
        chk("rst ready", {31'b0, cpu.mem_ready}, 32'd0);
        chk("rst rdata", cpu.mem_rdata, 32'd0);
        chk("rst ce/we", {27'b0, bram.bram_ce, bram.bram_we}, 32'd0);
        chk("rst addr/di", {22'b0, bram.bram_addr} | bram.bram_di, 32'd0);
        chk("rst err", {31'b0, err_misalign}, 32'd0);
        chk("rst bram_rst", {31'b0, bram.bram_rst}, 32'd1);
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed vector table.
        for (int i = 0; i < 10; i++)
            txn(tbl[i].addr, tbl[i].wdata, tbl[i].wstrb, tbl[i].exp_rdata, $sformatf("vec%0d", i));
        chk("err after aligned", {31'b0, err_misalign}, 32'd0);

        // Out of window: nothing may happen for 10 cycles.
        cpu.mem_valid = 1'b1; cpu.mem_addr = 32'h1000; cpu.mem_wstrb = 4'b1111; cpu.mem_wdata = 32'h12345678;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            chk($sformatf("oow ce c%0d", c), {31'b0, bram.bram_ce}, 32'd0);
            chk($sformatf("oow rdy c%0d", c), {31'b0, cpu.mem_ready}, 32'd0);
        end
        cpu.mem_valid = 1'b0;
        @(posedge clk); #1;

        // Misaligned read, mem_valid held across two transactions.
        cpu.mem_valid = 1'b1; cpu.mem_addr = 32'h13; cpu.mem_wstrb = 4'b0000;
        prev_rdy = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            if (c == 4) cpu.mem_valid = 1'b0;
            if (cpu.mem_ready) begin
                pulses.push_back(c);
                chk($sformatf("b2b rdata c%0d", c), cpu.mem_rdata, ref_mem[4]);
            end
            chk($sformatf("b2b no double rdy c%0d", c), {31'b0, prev_rdy & cpu.mem_ready}, 32'd0);
            prev_rdy = cpu.mem_ready;
        end
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            if (cpu.mem_ready) pulses.push_back(5 + c);
        end
        chk("b2b pulse count", pulses.size(), 32'd2);
        if (pulses.size() == 2) chk("b2b spacing", pulses[1] - pulses[0], 32'd3);
        chk("err after misalign", {31'b0, err_misalign}, 32'd1);

        // Random traffic against the reference memory.
        for (int k = 0; k < 60; k++) begin
            int w;
            w = $urandom_range(0, 15);
            a = (w * 4) | $urandom_range(0, 3);
            d = $urandom;
            s = ($urandom_range(0, 2) == 0) ? 4'b0000 : 4'($urandom);
            e = (s == 4'b0000) ? ref_mem[w] : 32'h0;
            txn(a, d, s, e, $sformatf("rnd%0d", k));
            if ($urandom_range(0, 3) == 0) begin
                cpu.mem_valid = 1'b1;
                cpu.mem_addr  = ($urandom_range(1, 32'hFFFFF) << 12) | $urandom_range(0, 4095);
                @(posedge clk); #1;
                chk($sformatf("rnd%0d oow ce", k), {31'b0, bram.bram_ce}, 32'd0);
                cpu.mem_valid = 1'b0;
            end
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        chk("err sticky", {31'b0, err_misalign}, 32'd1);

        // Reset in the middle of a write's ACC cycle.
        cpu.mem_valid = 1'b1; cpu.mem_addr = 32'h190; cpu.mem_wdata = 32'hFFFFFFFF; cpu.mem_wstrb = 4'b1111;
        @(posedge clk); #1;
        chk("abort ce before", {31'b0, bram.bram_ce}, 32'd1);
        cpu.mem_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("abort ce/we", {27'b0, bram.bram_ce, bram.bram_we}, 32'd0);
        chk("abort addr", {22'b0, bram.bram_addr}, 32'd0);
        chk("abort di", bram.bram_di, 32'd0);
        chk("abort err", {31'b0, err_misalign}, 32'd0);
        chk("abort bram_rst", {31'b0, bram.bram_rst}, 32'd1);
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            chk($sformatf("abort rdy c%0d", c), {31'b0, cpu.mem_ready}, 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post-rst rdy", {31'b0, cpu.mem_ready}, 32'd0);
        chk("post-rst ce", {31'b0, bram.bram_ce}, 32'd0);
        txn(32'h10, 32'h0, 4'b0000, ref_mem[4], "post-rst read");

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
